// File: rtl/lopd_pkg.sv
// Shared constants and types for the 24-bit leading-one position detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lopd_pkg;

  localparam int SIZE_DATA_DEF = 24;
  localparam int SIZE_LOPD_DEF = 5;
  localparam int NIBBLE_CNT    = 6;

  typedef logic [4:0] lopd_pos_t;

  // Zero count contributed by all nibbles above nibble k (nibble 5 is the MSB nibble).
  function automatic lopd_pos_t nibble_base(input int k);
    return lopd_pos_t'(4 * (NIBBLE_CNT - 1 - k));
  endfunction

endpackage

// File: rtl/lopd_4bit.sv
// Leading-zero count of one nibble (bit 3 = MSB) plus an all-zero flag.
// Latency: purely combinational.
// Backpressure: none; evaluates every input value.
module lopd_4bit (
  input  logic [3:0] i_nib,
  output logic [1:0] o_cnt,
  output logic       o_zero
);

  // Priority encode from bit 3 down; an all-zero nibble reports count 0 and relies on o_zero.
  always_comb begin
    o_cnt = 2'd0;
    if (i_nib[3])      o_cnt = 2'd0;
    else if (i_nib[2]) o_cnt = 2'd1;
    else if (i_nib[1]) o_cnt = 2'd2;
    else if (i_nib[0]) o_cnt = 2'd3;
    o_zero = (i_nib == 4'd0);
  end

endmodule

// File: rtl/lopd_24bit.sv
// Leading-one detector: zeros above the highest set bit of a 24-bit word, plus all-zero flag.
// Latency: 0 cycles by default; 1 cycle when LOPD_24BIT_REG_OUT_EN is defined.
// Backpressure: none; a new word may be applied every cycle.
module lopd_24bit
  import lopd_pkg::*;
#(
  parameter int SIZE_DATA = SIZE_DATA_DEF,
  parameter int SIZE_LOPD = SIZE_LOPD_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic                 o_zero_flag
);

  // Nibble-level results; index 5 covers bits 23:20.
  logic [1:0]            w_nib_cnt  [NIBBLE_CNT];
  logic [NIBBLE_CNT-1:0] w_nib_zero;
  lopd_pos_t             w_pos;
  logic                  w_found;
  logic                  w_zero;

  for (genvar g = 0; g < NIBBLE_CNT; g++) begin : g_nib
    lopd_4bit u_nib (
      .i_nib  (i_data[4*g +: 4]),
      .o_cnt  (w_nib_cnt[g]),
      .o_zero (w_nib_zero[g])
    );
  end

  // Combine: the first non-zero nibble from the MSB side decides the position.
  // An all-zero word falls through with position 0 rather than 24.
  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = NIBBLE_CNT - 1; k >= 0; k--) begin
      if (!w_found && !w_nib_zero[k]) begin
        w_found = 1'b1;
        w_pos   = nibble_base(k) + lopd_pos_t'(w_nib_cnt[k]);
      end
    end
    w_zero = &w_nib_zero;
  end

`ifdef LOPD_24BIT_REG_OUT_EN
  logic [SIZE_LOPD-1:0] r_one_position;
  logic                 r_zero_flag;

  // Output register; reset wins over capture and reports the all-zero encoding.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_one_position <= '0;
      r_zero_flag    <= 1'b1;
    end else begin
      r_one_position <= w_pos;
      r_zero_flag    <= w_zero;
    end
  end

  assign o_one_position = r_one_position;
  assign o_zero_flag    = r_zero_flag;
`else
  // Clock and reset are kept on the port list so both builds share one footprint.
  logic w_unused;
  assign w_unused = &{1'b0, i_clk, i_rst_n};

  assign o_one_position = w_pos;
  assign o_zero_flag    = w_zero;
`endif

endmodule

// File: tb/tb_lopd_24bit.sv
// Self-checking bench for lopd_24bit (combinational build, or registered with LOPD_24BIT_REG_OUT_EN).
// Latency: follows the build; the apply task hides the difference.
// Backpressure: n/a.
module tb_lopd_24bit;

  logic        clk;
  logic        rst_n;
  logic [23:0] data;
  logic [4:0]  pos;
  logic        zf;

  int n_chk  = 0;
  int n_pass = 0;

  lopd_24bit #(.SIZE_DATA(24), .SIZE_LOPD(5)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_data         (data),
    .o_one_position (pos),
    .o_zero_flag    (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NV = 12;
  localparam logic [23:0] V_DAT [NV] = '{
    24'h000000, 24'h800000, 24'h7FFFFF, 24'h000001, 24'h00F000, 24'h001FFF,
    24'h000010, 24'h00FFFF, 24'h0F0000, 24'h000008, 24'h400000, 24'h000002};
  localparam int V_POS [NV] = '{0, 0, 1, 23, 8, 11, 19, 8, 4, 20, 1, 22};
  localparam int V_ZF  [NV] = '{1, 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Golden model: walk from bit 23 down, counting zeros until the first one.
  function automatic int ref_pos(input logic [23:0] d);
    int n;
    n = 0;
    for (int b = 23; b >= 0; b--) begin
      if (d[b]) return n;
      n++;
    end
    return 0;
  endfunction

  // Drive one word and return when the matching result is visible.
  task automatic apply(input logic [23:0] d);
`ifdef LOPD_24BIT_REG_OUT_EN
    @(negedge clk);
    data = d;
    @(posedge clk);
    #1;
`else
    data = d;
    #1;
`endif
  endtask

  initial begin
    logic [23:0] v;
    rst_n = 1'b0;
    data  = 24'h000000;

`ifdef LOPD_24BIT_REG_OUT_EN
    @(posedge clk);
    #1;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_zf",  32'(zf),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
`else
    #1;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_zf",  32'(zf),  32'd1);
    // Reset must not influence the combinational outputs.
    data = 24'h000100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ign_pos", 32'(pos), 32'd15);
    chk("rst_ign_zf",  32'(zf),  32'd0);
    rst_n = 1'b1;
`endif

    for (int i = 0; i < NV; i++) begin
      apply(V_DAT[i]);
      chk($sformatf("dir_pos_%06h", V_DAT[i]), 32'(pos), 32'(V_POS[i]));
      chk($sformatf("dir_zf_%06h",  V_DAT[i]), 32'(zf),  32'(V_ZF[i]));
    end

    for (int i = 0; i < 120; i++) begin
      v = 24'($urandom());
      v = v >> $urandom_range(0, 24);
      apply(v);
      chk($sformatf("rnd_pos_%06h", v), 32'(pos), 32'(ref_pos(v)));
      chk($sformatf("rnd_zf_%06h",  v), 32'(zf),  32'(v == 24'd0));
    end

`ifdef LOPD_24BIT_REG_OUT_EN
    // One-cycle latency, then reset overriding capture, then first result after release.
    apply(24'h000010);
    chk("reg_pos_19", 32'(pos), 32'd19);
    chk("reg_zf_19",  32'(zf),  32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    data  = 24'h000001;
    @(posedge clk);
    #1;
    chk("midrst_pos", 32'(pos), 32'd0);
    chk("midrst_zf",  32'(zf),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    data  = 24'h000100;
    @(posedge clk);
    #1;
    chk("post_rst_pos", 32'(pos), 32'd15);
    chk("post_rst_zf",  32'(zf),  32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lopd_24bit.md
LOPD_24BIT -- requirements
Module: lopd_24bit

Interface
- REQ-001: Parameter SIZE_DATA SHALL be: SIZE_DATA, default 24, input data width in bits.
- REQ-002: Parameter SIZE_LOPD SHALL be: SIZE_LOPD, default 5, position output width (ceil(log2(24))).
- REQ-003: Port i_clk SHALL be: i_clk  input  1  single clock; all sequential logic on its rising edge.
- REQ-004: Port i_rst_n SHALL be: i_rst_n  input  1  reset, synchronous, active-low.
- REQ-005: Port i_data SHALL be: i_data  input  SIZE_DATA  data word to scan, bit 23 = MSB.
- REQ-006: Port o_one_position SHALL be: o_one_position  output  SIZE_LOPD  count of zeros above the leading one (0..23).
- REQ-007: Port o_zero_flag SHALL be: o_zero_flag  output  1  high when i_data is all zeros.

Function
- REQ-008: o_one_position SHALL equal the number of consecutive 0 bits from bit 23 down to the highest set bit (0x800000 -> 0; 0x000001 -> 23).
- REQ-009: For i_data == 0, o_zero_flag SHALL be 1 and o_one_position SHALL be 0, not 24.
- REQ-010: For any nonzero i_data, o_zero_flag SHALL be 0.
- REQ-011: Bits below the leading one SHALL NOT affect either output.
- REQ-012: In default build, outputs SHALL be purely combinational from i_data (zero-cycle latency), settled within 1 ns of an input change in RTL simulation, with no clock dependency.
- REQ-013: No handshake exists; a new i_data may be applied every cycle and every value SHALL be evaluated.
- REQ-014: Outputs SHALL never be X/Z for a fully known i_data.

Reset
- REQ-015: In default (combinational) build, i_rst_n SHALL have no effect on the outputs.
- REQ-016: In registered build, i_rst_n low at a rising i_clk edge SHALL set o_one_position=0 and o_zero_flag=1, overriding the data capture on that edge.
- REQ-017: Reset asserted mid-stream SHALL discard the in-flight result; the first result after release SHALL correspond to the i_data sampled on the first edge with i_rst_n high.

Configuration
- REQ-018: Macro LOPD_24BIT_REG_OUT_EN, when defined, SHALL add one output register stage: outputs reflect i_data sampled at the previous rising edge (1-cycle latency).
- REQ-019: When LOPD_24BIT_REG_OUT_EN is undefined, outputs SHALL be combinational per REQ-012, and i_clk/i_rst_n SHALL be present but unused.

Structure
- REQ-020: Package lopd_pkg SHALL hold SIZE_DATA_DEF=24, SIZE_LOPD_DEF=5, NIBBLE_CNT=6, and a typedef for the position type logic [4:0].
- REQ-021: Sub-module lopd_4bit SHALL encode one nibble to a 2-bit leading-zero count plus an all-zero flag.
- REQ-022: Six lopd_4bit instances (nibbles 5..0, MSB first) SHALL feed a priority combiner: position = 4*(index of first nonzero nibble from MSB) + that nibble's local count; global zero = AND of nibble zero flags.

Verification
- REQ-023: i_data=0x000000 -> o_one_position=0, o_zero_flag=1.
- REQ-024: i_data=0x800000 -> 0, 0; i_data=0x7FFFFF -> 1, 0.
- REQ-025: i_data=0x000001 -> 23, 0; i_data=0x00F000 -> 8, 0; i_data=0x001FFF -> 11, 0.
- REQ-026: 100+ random 24-bit values checked against a golden MSB-down zero-count model; 100% pass required.
- REQ-027: With LOPD_24BIT_REG_OUT_EN defined, drive 0x000010 -> outputs 19, 0 one edge later; assert i_rst_n=0 for one edge -> outputs 0, 1 on that edge.
